mult_ctrl: RTL and testbench

- Moore FSM that sequences the 32-bit shift-add multiplier datapath: load operands, iterate SIZE add/shift steps, flag completion.
- Drives the datapath's mux selects (a_sel, b_sel, prod_sel, add_sel) and register enable; consumes its b_lsb status.
- Exposes a start/busy/done handshake to the requesting unit.

---
 rtl/mult_ctrl_if.sv | 50 +++++
 rtl/mult_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_ctrl_if
//  Description : Signal bundle between the shift-add multiplier controller,
//                its requesting unit and its datapath. Abort signals exist
//                only when MULT_CTRL_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_ctrl_if;
  // Requester handshake
  logic start;
  logic busy;
  logic done;
  // Datapath control and status
  logic b_lsb;
  logic a_sel;
  logic b_sel;
  logic prod_sel;
  logic add_sel;
  logic enable;
`ifdef MULT_CTRL_ABORT_EN
  logic abort;
  logic aborted;

  // Requester/datapath side
  modport master (
    output start, b_lsb, abort,
    input  busy, done, a_sel, b_sel, prod_sel, add_sel, enable, aborted
  );

  // Controller side
  modport slave (
    input  start, b_lsb, abort,
    output busy, done, a_sel, b_sel, prod_sel, add_sel, enable, aborted
  );
`else
  // Requester/datapath side
  modport master (
    output start, b_lsb,
    input  busy, done, a_sel, b_sel, prod_sel, add_sel, enable
  );

  // Controller side
  modport slave (
    input  start, b_lsb,
    output busy, done, a_sel, b_sel, prod_sel, add_sel, enable
  );
`endif
endinterface : mult_ctrl_if
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_ctrl
//  Description : Moore FSM sequencing a shift-add multiplier datapath:
//                LOAD operands, SIZE add/shift RUN steps, one-cycle DONE.
//                Optional abort support when MULT_CTRL_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_ctrl #(
  parameter int SIZE  = 32,  // operand width / number of iterations
  parameter int CNT_W = 6    // iteration counter width, 2**CNT_W > SIZE
) (
  input  wire logic  clk,
  input  wire logic  reset,  // asynchronous, active low
  mult_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SIZE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // b_lsb already shows the post-edge B bit 0, so it is delayed one cycle
  // to give add_sel the bit currently held in register B.
  logic             lsb_q, lsb_d;
`ifdef MULT_CTRL_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  // State, counter and delayed LSB registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lsb_q     <= 1'b0;
`ifdef MULT_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lsb_q     <= lsb_d;
`ifdef MULT_CTRL_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Next-state, counter and LSB capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lsb_d     = lsb_q;
`ifdef MULT_CTRL_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        lsb_d   = bus.b_lsb;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        lsb_d = bus.b_lsb;
        // Counter stops at its last value so it never wraps
        if (cnt_q == c_cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef MULT_CTRL_ABORT_EN
    // Abort takes priority over the final RUN -> DONE transition
    if (bus.abort && (state_q == S_LOAD || state_q == S_RUN)) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
`endif
  end

  // Moore output decode from state and lsb_q only
  always_comb begin
    bus.enable   = 1'b0;
    bus.a_sel    = 1'b0;
    bus.b_sel    = 1'b0;
    bus.prod_sel = 1'b0;
    bus.add_sel  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.enable = 1'b1;
        bus.busy   = 1'b1;
      end
      S_RUN: begin
        bus.enable   = 1'b1;
        bus.a_sel    = 1'b1;
        bus.b_sel    = 1'b1;
        bus.prod_sel = 1'b1;
        bus.add_sel  = lsb_q;
        bus.busy     = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef MULT_CTRL_ABORT_EN
  assign bus.aborted = aborted_q;
`endif

endmodule : mult_ctrl
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_ctrl
//  Description : Directed self-checking bench for mult_ctrl driving a
//                behavioural 32x32 shift-add multiplier datapath.
//                Abort steps are included when MULT_CTRL_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_ctrl_if bus ();

  mult_ctrl #(.SIZE(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural datapath: registers A (64b), B (32b), PROD (64b)
  logic [31:0] a_in, b_in;
  logic [63:0] a_q, prod_q, mux_a, prod_d;
  logic [31:0] b_q, mux_b;

  always_comb begin
    mux_a  = bus.a_sel ? (a_q << 1) : {32'd0, a_in};
    mux_b  = bus.b_sel ? (b_q >> 1) : b_in;
    prod_d = !bus.prod_sel ? 64'd0 : (bus.add_sel ? prod_q + a_q : prod_q);
  end
  assign bus.b_lsb = mux_b[0];

  always_ff @(posedge clk) begin
    if (bus.enable) begin
      a_q    <= mux_a;
      b_q    <= mux_b;
      prod_q <= prod_d;
    end
  end

  int n_checks = 0, n_err = 0;
  int edge_cnt = 0, busy_n = 0, add_n = 0, done_n = 0, aborted_n = 0;
  int done_edge = 0, load_edge = 0, start_edge = 0;

  function automatic logic [6:0] outs();
    return {bus.enable, bus.busy, bus.done, bus.a_sel, bus.b_sel,
            bus.prod_sel, bus.add_sel};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge and log activity
  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
    if (bus.busy)    busy_n++;
    if (bus.add_sel) add_n++;
    if (bus.done) begin
      done_n++;
      done_edge = edge_cnt;
    end
    if (bus.busy && !bus.a_sel) load_edge = edge_cnt;
`ifdef MULT_CTRL_ABORT_EN
    if (bus.aborted) aborted_n++;
`endif
  endtask

  task automatic clear_counts();
    busy_n = 0; add_n = 0; done_n = 0; aborted_n = 0;
  endtask

  // Wait for IDLE, then pulse start for one edge; returns in the LOAD cycle
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 5 && (bus.busy || bus.done); i++) tick();
    a_in = a;
    b_in = b;
    clear_counts();
    bus.start = 1'b1;
    tick();
    start_edge = edge_cnt;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && !bus.done; i++) tick();
    check(tag, {63'd0, bus.done}, 64'd1);
  endtask

  // Start sampled at edge k: LOAD, 32 RUN cycles, done sampled after edge k+33
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_prod, input int exp_adds);
    start_op(a, b);
    wait_done({tag, "_done"}, 60);
    check({tag, "_latency"}, 64'(done_edge - start_edge), 64'd33);
    check({tag, "_prod"},    prod_q,                      exp_prod);
    check({tag, "_busy"},    64'(busy_n),                 64'd33);
    check({tag, "_adds"},    64'(add_n),                  64'(exp_adds));
  endtask

  initial begin
    int d1;
    bus.start = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    a_in = '0;
    b_in = '0;

    // Reset state
    tick();
    tick();
    check("reset_outs", {57'd0, outs()}, 64'd0);
    #3 reset = 1'b1;
    tick();
    check("idle_outs", {57'd0, outs()}, 64'd0);

    // Basic products
    run_mul("m3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F, 2);
    run_mul("mfxf",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32);
    run_mul("mbx0",   32'h1234_5678,  32'd0,          64'd0,                   0);

    // Product holds while idle
    tick(); tick(); tick();
    check("prod_hold", prod_q, 64'd0);
    check("idle_enable", {63'd0, bus.enable}, 64'd0);

    // Start re-pulsed mid-RUN is ignored
    start_op(32'd6, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("repulse_done", 60);
    check("repulse_latency", 64'(done_edge - start_edge), 64'd33);
    check("repulse_prod", prod_q, 64'd42);
    for (int i = 0; i < 4; i++) tick();
    check("repulse_single", 64'(done_n), 64'd1);
    check("repulse_busy", 64'(busy_n), 64'd33);

    // Start held high: second LOAD two cycles after first done
    for (int i = 0; i < 5 && (bus.busy || bus.done); i++) tick();
    a_in = 32'd3;
    b_in = 32'd5;
    clear_counts();
    bus.start = 1'b1;
    tick();
    wait_done("held_done1", 60);
    d1 = done_edge;
    for (int i = 0; i < 6 && load_edge <= d1; i++) tick();
    check("held_gap", 64'(load_edge - d1), 64'd2);
    bus.start = 1'b0;
    wait_done("held_done2", 60);
    check("held_latency2", 64'(done_edge - load_edge), 64'd33);
    check("held_prod2", prod_q, 64'd15);

    // Asynchronous reset mid-RUN at cnt=10
    start_op(32'hDEAD_BEEF, 32'hFFFF_0000);
    for (int i = 0; i < 11; i++) tick();
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {57'd0, outs()}, 64'd0);
    #1 reset = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_idle", 64'(busy_n + done_n), 64'd0);
    run_mul("m7x9", 32'd7, 32'd9, 64'd63, 2);

`ifdef MULT_CTRL_ABORT_EN
    // Abort at RUN cnt=5
    start_op(32'd11, 32'd13);
    for (int i = 0; i < 6; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_pulse", {63'd0, bus.aborted}, 64'd1);
    check("abort_outs", {57'd0, outs()}, 64'd0);
    tick();
    check("abort_clear", {63'd0, bus.aborted}, 64'd0);
    for (int i = 0; i < 40; i++) tick();
    check("abort_no_done", 64'(done_n), 64'd0);
    check("abort_count", 64'(aborted_n), 64'd1);
    run_mul("m11x13", 32'd11, 32'd13, 64'd143, 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_mult_ctrl
`default_nettype wire
